// File: rtl/sr_ff_pkg.sv
// Shared definitions for the SR flip-flop bank: invalid-condition modes and
// the decoded per-bit SR command.
package sr_ff_pkg;

    localparam int MODE_HOLD   = 0;
    localparam int MODE_SET    = 1;
    localparam int MODE_RST    = 2;
    localparam int MODE_TOGGLE = 3;

    // Encoding matches {S, R} so decoding is a plain concatenation.
    typedef enum logic [1:0] {
        HOLD = 2'b00,
        CLR  = 2'b01,
        SET  = 2'b10,
        BAD  = 2'b11
    } sr_cmd_t;

    function automatic sr_cmd_t decode_sr(input logic s, input logic r);
        return sr_cmd_t'({s, r});
    endfunction

endpackage

// File: rtl/sr_ff_cell.sv
// One SR storage bit: next-state rule plus the registered forbidden-input flag.
module sr_ff_cell
    import sr_ff_pkg::*;
#(
    parameter int INVALID_MODE = MODE_HOLD
) (
    input  logic clk,
    input  logic rst,
    input  logic s,
    input  logic r,
    output logic q,
    output logic invalid
);

    sr_cmd_t cmd;
    logic    q_next;

    // The response to S=R=1 is fixed at elaboration time by INVALID_MODE.
    always_comb begin
        cmd    = decode_sr(s, r);
        q_next = q;
        case (cmd)
            HOLD: q_next = q;
            CLR:  q_next = 1'b0;
            SET:  q_next = 1'b1;
            BAD: begin
                case (INVALID_MODE)
                    MODE_SET:    q_next = 1'b1;
                    MODE_RST:    q_next = 1'b0;
                    MODE_TOGGLE: q_next = ~q;
                    default:     q_next = q;
                endcase
            end
            default: q_next = q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q       <= 1'b0;
            invalid <= 1'b0;
        end else begin
            q       <= q_next;
            invalid <= (cmd == BAD);
        end
    end

endmodule

// File: rtl/sr_ff.sv
// Bank of WIDTH clocked SR flops with complementary outputs and tracking of
// forbidden S=R=1 events (sticky error flag and saturating event counter).
module sr_ff
    import sr_ff_pkg::*;
#(
    parameter int WIDTH        = 1,
    parameter int INVALID_MODE = MODE_HOLD,
    parameter int CNT_W        = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Qbar,
    output logic [WIDTH-1:0] invalid,
    output logic             err_sticky,
    output logic [CNT_W-1:0] inv_count
);

    logic any_bad;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        sr_ff_cell #(
            .INVALID_MODE(INVALID_MODE)
        ) u_cell (
            .clk    (clk),
            .rst    (rst),
            .s      (S[i]),
            .r      (R[i]),
            .q      (Q[i]),
            .invalid(invalid[i])
        );
    end

    // Qbar has no storage of its own, so it can never disagree with Q.
    assign Qbar    = ~Q;
    assign any_bad = |(S & R);

    // Several bits going bad in the same cycle count as a single event.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_sticky <= 1'b0;
            inv_count  <= '0;
        end else if (any_bad) begin
            err_sticky <= 1'b1;
            if (inv_count != {CNT_W{1'b1}}) begin
                inv_count <= inv_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_sr_ff.sv
// Directed self-checking bench for sr_ff: one DUT per configuration under test,
// all sharing the clock and reset.
module tb_sr_ff;

    logic clk = 1'b0;
    logic rst;

    logic s0, r0, q0, qb0, inv0, err0;
    logic [7:0] cnt0;

    logic s_m, r_m;
    logic q1, qb1, inv1, err1, q2, qb2, inv2, err2, q3, qb3, inv3, err3;
    logic [7:0] cnt1, cnt2, cnt3;

    logic s_sat, r_sat, q_sat, qb_sat, inv_sat, err_sat;
    logic [1:0] cnt_sat;

    logic [3:0] s4, r4, q4, qb4, inv4;
    logic       err4;
    logic [7:0] cnt4;

    int check_count = 0;
    int pass_count  = 0;

    always #5 clk = ~clk;

    sr_ff #(.WIDTH(1), .INVALID_MODE(0), .CNT_W(8)) dut0 (
        .clk(clk), .rst(rst), .S(s0), .R(r0), .Q(q0), .Qbar(qb0),
        .invalid(inv0), .err_sticky(err0), .inv_count(cnt0));
    sr_ff #(.WIDTH(1), .INVALID_MODE(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst(rst), .S(s_m), .R(r_m), .Q(q1), .Qbar(qb1),
        .invalid(inv1), .err_sticky(err1), .inv_count(cnt1));
    sr_ff #(.WIDTH(1), .INVALID_MODE(2), .CNT_W(8)) dut2 (
        .clk(clk), .rst(rst), .S(s_m), .R(r_m), .Q(q2), .Qbar(qb2),
        .invalid(inv2), .err_sticky(err2), .inv_count(cnt2));
    sr_ff #(.WIDTH(1), .INVALID_MODE(3), .CNT_W(8)) dut3 (
        .clk(clk), .rst(rst), .S(s_m), .R(r_m), .Q(q3), .Qbar(qb3),
        .invalid(inv3), .err_sticky(err3), .inv_count(cnt3));
    sr_ff #(.WIDTH(1), .INVALID_MODE(0), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .S(s_sat), .R(r_sat), .Q(q_sat), .Qbar(qb_sat),
        .invalid(inv_sat), .err_sticky(err_sat), .inv_count(cnt_sat));
    sr_ff #(.WIDTH(4), .INVALID_MODE(0), .CNT_W(8)) dut4 (
        .clk(clk), .rst(rst), .S(s4), .R(r4), .Q(q4), .Qbar(qb4),
        .invalid(inv4), .err_sticky(err4), .inv_count(cnt4));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        s0 = 1'b1; r0 = 1'b0; s_m = 1'b1; r_m = 1'b0;
        s_sat = 1'b1; r_sat = 1'b0; s4 = 4'hF; r4 = 4'h0;
        step();
        step();
        check_count++;
        if (q0 !== 1'b0 || qb0 !== 1'b1) $display("[TB] FAIL reset_q: Q=%b Qbar=%b required Q=0 Qbar=1", q0, qb0);
        else pass_count++;
        check_count++;
        if (inv0 !== 1'b0 || err0 !== 1'b0 || cnt0 !== 8'd0)
            $display("[TB] FAIL reset_flags: invalid=%b err=%b cnt=%0d required 0/0/0", inv0, err0, cnt0);
        else pass_count++;
        check_count++;
        if (q4 !== 4'h0 || qb4 !== 4'hF || q1 !== 1'b0 || q3 !== 1'b0)
            $display("[TB] FAIL reset_others: Q4=%b Qbar4=%b Q1=%b Q3=%b required 0000/1111/0/0", q4, qb4, q1, q3);
        else pass_count++;
        rst = 1'b0;
        s0 = 1'b0; s_m = 1'b0; s_sat = 1'b0; s4 = 4'h0;
    endtask

    task automatic test_truth_table();
        logic [1:0] pats  [4] = '{2'b00, 2'b01, 2'b10, 2'b00};
        logic       exp_q [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            {s0, r0} = pats[i];
            step();
            check_count++;
            if (q0 !== exp_q[i] || qb0 !== ~exp_q[i])
                $display("[TB] FAIL truth_%0d: Q=%b Qbar=%b required Q=%b Qbar=%b", i, q0, qb0, exp_q[i], ~exp_q[i]);
            else pass_count++;
        end
    endtask

    task automatic test_invalid_hold();
        s0 = 1'b1; r0 = 1'b1;
        step();
        check_count++;
        if (q0 !== 1'b1 || qb0 !== 1'b0 || inv0 !== 1'b1 || err0 !== 1'b1 || cnt0 !== 8'd1)
            $display("[TB] FAIL invalid_hold: Q=%b Qbar=%b inv=%b err=%b cnt=%0d required 1/0/1/1/1",
                     q0, qb0, inv0, err0, cnt0);
        else pass_count++;
        s0 = 1'b0; r0 = 1'b0;
        step();
        check_count++;
        if (inv0 !== 1'b0 || err0 !== 1'b1 || cnt0 !== 8'd1 || q0 !== 1'b1)
            $display("[TB] FAIL invalid_after: inv=%b err=%b cnt=%0d Q=%b required 0/1/1/1", inv0, err0, cnt0, q0);
        else pass_count++;
    endtask

    task automatic test_back_to_back();
        s0 = 1'b1; r0 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_count++;
            if (inv0 !== 1'b1 || cnt0 !== 8'(2 + i) || q0 !== 1'b1)
                $display("[TB] FAIL b2b_%0d: inv=%b cnt=%0d Q=%b required 1/%0d/1", i, inv0, cnt0, q0, 2 + i);
            else pass_count++;
        end
        s0 = 1'b0; r0 = 1'b0;
    endtask

    task automatic test_between_edges();
        @(negedge clk);
        r0 = 1'b1;
        #2;
        r0 = 1'b0;
        step();
        check_count++;
        if (q0 !== 1'b1 || inv0 !== 1'b0) $display("[TB] FAIL glitch: Q=%b inv=%b required 1/0", q0, inv0);
        else pass_count++;
    endtask

    task automatic test_modes();
        s_m = 1'b1; r_m = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check_count++;
            if (q1 !== 1'b1 || qb1 !== 1'b0) $display("[TB] FAIL mode_set_%0d: Q=%b Qbar=%b required 1/0", i, q1, qb1);
            else pass_count++;
            check_count++;
            if (q2 !== 1'b0 || qb2 !== 1'b1) $display("[TB] FAIL mode_rst_%0d: Q=%b Qbar=%b required 0/1", i, q2, qb2);
            else pass_count++;
            check_count++;
            if (q3 !== (i == 0) || qb3 !== (i != 0))
                $display("[TB] FAIL mode_toggle_%0d: Q=%b Qbar=%b required %b/%b", i, q3, qb3, i == 0, i != 0);
            else pass_count++;
            check_count++;
            if (inv1 !== 1'b1 || inv3 !== 1'b1 || err2 !== 1'b1 || cnt3 !== 8'(i + 1))
                $display("[TB] FAIL mode_flags_%0d: inv1=%b inv3=%b err2=%b cnt3=%0d required 1/1/1/%0d",
                         i, inv1, inv3, err2, cnt3, i + 1);
            else pass_count++;
        end
        s_m = 1'b0; r_m = 1'b0;
    endtask

    task automatic test_multibit();
        s4 = 4'b0101; r4 = 4'b0011;
        step();
        check_count++;
        if (q4 !== 4'b0100 || qb4 !== 4'b1011)
            $display("[TB] FAIL multibit_q: Q=%b Qbar=%b required 0100/1011", q4, qb4);
        else pass_count++;
        check_count++;
        if (inv4 !== 4'b0001 || cnt4 !== 8'd1 || err4 !== 1'b1)
            $display("[TB] FAIL multibit_flags: inv=%b cnt=%0d err=%b required 0001/1/1", inv4, cnt4, err4);
        else pass_count++;
        s4 = 4'b1111; r4 = 4'b1111;
        step();
        check_count++;
        if (inv4 !== 4'b1111 || cnt4 !== 8'd2)
            $display("[TB] FAIL multibit_once: inv=%b cnt=%0d required 1111/2", inv4, cnt4);
        else pass_count++;
        s4 = 4'h0; r4 = 4'h0;
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        s_sat = 1'b1; r_sat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_count++;
            if (cnt_sat !== exp_cnt[i] || inv_sat !== 1'b1)
                $display("[TB] FAIL sat_%0d: cnt=%0d inv=%b required %0d/1", i, cnt_sat, inv_sat, exp_cnt[i]);
            else pass_count++;
        end
        rst = 1'b1;
        step();
        check_count++;
        if (cnt_sat !== 2'd0 || err_sat !== 1'b0 || inv_sat !== 1'b0 || q_sat !== 1'b0 || qb_sat !== 1'b1)
            $display("[TB] FAIL sat_reset: cnt=%0d err=%b inv=%b Q=%b Qbar=%b required 0/0/0/0/1",
                     cnt_sat, err_sat, inv_sat, q_sat, qb_sat);
        else pass_count++;
        rst = 1'b0;
        s_sat = 1'b1; r_sat = 1'b0;
        step();
        check_count++;
        if (q_sat !== 1'b1 || cnt_sat !== 2'd0 || err_sat !== 1'b0)
            $display("[TB] FAIL resume: Q=%b cnt=%0d err=%b required 1/0/0", q_sat, cnt_sat, err_sat);
        else pass_count++;
        s_sat = 1'b0; r_sat = 1'b0;
    endtask

    initial begin
        test_reset();
        test_truth_table();
        test_invalid_hold();
        test_back_to_back();
        test_between_edges();
        test_modes();
        test_multibit();
        test_saturation();
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/sr_ff.md
# sr_ff

Clocked SR flip-flop bank: synchronous set/reset storage with a guaranteed-complementary output pair. It also detects and counts the forbidden S=R=1 condition. It serves as a general-purpose control latch for flag and status bits, such as sticky event and mode bits, wherever set and clear come from independent sources. The default configuration is a single-bit classic SR flop.

## Interface
Parameters:
- WIDTH, 1: number of independent SR bits.
- INVALID_MODE, 0: response per bit to S=R=1.
  - 0: hold.
  - 1: set-dominant.
  - 2: reset-dominant.
  - 3: toggle.
- CNT_W, 8: width of the invalid-event counter.

Ports:
- clk, input, 1: rising-edge clock; single clock domain.
- rst, input, 1: reset, synchronous and active-high.
- S, input, WIDTH: per-bit set request.
- R, input, WIDTH: per-bit reset request.
- Q, output, WIDTH: stored state.
- Qbar, output, WIDTH: complement of Q.
- invalid, output, WIDTH: registered per-bit flag, high for one cycle after S=R=1 was sampled on that bit.
- err_sticky, output, 1: set when any invalid event is sampled; cleared only by rst.
- inv_count, output, CNT_W: number of cycles in which any bit sampled S=R=1; saturates at all-ones.

## Operation
- All state updates on the rising clk edge only; no combinational path from S or R to any output.
- Per bit i, based on (S[i], R[i]):
  - 00: Q[i] holds.
  - 01: Q[i] becomes 0.
  - 10: Q[i] becomes 1.
  - 11: action selected by INVALID_MODE, and invalid[i] is asserted for that cycle.
- INVALID_MODE actions on 11:
  - 0: hold.
  - 1: Q[i] becomes 1.
  - 2: Q[i] becomes 0.
  - 3: Q[i] becomes ~Q[i].
- Qbar is always exactly ~Q, including in reset and on 11; the pair is never equal.
- invalid[i] is the registered value of S[i]&R[i]; it is 0 in any cycle without 11.
- err_sticky becomes 1 in the cycle after any bit samples 11 and stays 1 until rst.
- inv_count increments by 1 per cycle in which at least one bit samples 11. Multiple bits in the same cycle count once. The counter holds at 2^CNT_W-1 once reached.
- rst has priority over S and R: while rst is high, S and R are ignored and no invalid event is recorded.

## Timing
- Latency: 1 clock from S/R sampling to Q, Qbar, invalid, err_sticky and inv_count.
- Values after a clock edge with rst high:
  - Q = 0.
  - Qbar = all-ones.
  - invalid = 0.
  - err_sticky = 0.
  - inv_count = 0.
- Before the first reset edge, outputs are undefined; the bench applies rst before checking.
- Reset mid-operation: the next edge forces reset values regardless of S and R. Normal operation resumes on the first edge with rst low.
- Input changes between edges have no effect; only values present at the edge matter.
- Back-to-back 11 cycles: invalid stays high continuously, and inv_count increments every cycle until saturation.

## Structure
- Shared package:
  - INVALID_MODE encodings as named constants (MODE_HOLD=0, MODE_SET=1, MODE_RST=2, MODE_TOGGLE=3).
  - An SR-command enum (HOLD, CLR, SET, BAD).
- Natural sub-module sr_ff_cell: a one-bit register implementing the next-state rule and the per-bit invalid flag. It is instantiated WIDTH times by a generate loop.
- The top level holds err_sticky, the saturating counter and the OR-reduction of the invalid conditions.
- Q is the only storage element per bit; Qbar is derived as ~Q so the outputs cannot diverge.

## Test plan
- Reset: hold rst=1 with S=1, R=0 for 2 edges. Expect Q=0, Qbar=1, invalid=0, err_sticky=0, inv_count=0.
- Basic truth table, WIDTH=1, MODE 0: drive SR=00, 01, 10, 00 over 4 edges. Expect Q=0, 0, 1, 1 and Qbar = ~Q after each edge.
- Invalid event, MODE 0, starting from Q=1: drive SR=11 for 1 edge. Expect Q=1 held, invalid=1 for one cycle, err_sticky=1, inv_count=1. Then SR=00 gives invalid=0 while err_sticky stays 1.
- Mode coverage from Q=0, SR=11 for 2 edges:
  - MODE 1: Q=1, 1.
  - MODE 2: Q=0, 0.
  - MODE 3: Q=1, 0.
- Saturation with CNT_W=2: drive SR=11 for 5 edges. Expect inv_count=1, 2, 3, 3, 3. Then rst for 1 edge with SR=11 gives inv_count=0 and err_sticky=0.
- Multi-bit, WIDTH=4: drive S=0101, R=0011 in one edge from Q=0000. Expect Q=0100, Qbar=1011, invalid=0001, inv_count +1.
